regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//   Parametrised multi-read-port general register file for the MIPS datapath, generalising the decode-stage regfile.
//   Adds same-cycle write-to-read bypass, a per-register busy scoreboard for in-flight loads/long ops, and a sequential clear FSM.
//   Sits between the instruction decoder (addresses, issue) and the writeback mux (wr_*); read data feeds the ALU/store path.
// PARAMETERS
//   DATA_W    32  register width in bits
//   ADDR_W    5   register address width; DEPTH = 2**ADDR_W registers
//   NUM_RD    2   number of independent combinational read ports (1..4)
//   BYPASS    1   1: read returns wr_data when same-cycle write hits read address; 0: read returns stored value
//   ZERO_REG  1   1: register 0 reads 0, writes/issues to it ignored; 0: register 0 is ordinary
// PORTS
//   clock       in   1               rising-edge clock
//   reset       in   1               synchronous, active-high; starts clear sequence
//   rd_addr     in   NUM_RD*ADDR_W   packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data     out  NUM_RD*DATA_W   packed read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy     out  NUM_RD          port k address has a pending (issued, unwritten) producer
//   stall       out  1               OR of rd_busy bits, or ready==0
//   wr_en       in   1               write strobe
//   wr_addr     in   ADDR_W          write address
//   wr_data     in   DATA_W          write data
//   issue_en    in   1               mark issue_addr busy (producer dispatched)
//   issue_addr  in   ADDR_W          register whose result is now pending
//   ready       out  1               clear sequence finished, file usable
// BEHAVIOUR
//   FSM: CLEAR -> RUN. reset (any state, any cycle) -> CLEAR with clr_idx=0 at next edge.
//   CLEAR: one register zeroed per cycle at clr_idx, busy[clr_idx]<=0, clr_idx++; after index DEPTH-1 -> RUN.
//     Clear takes exactly DEPTH cycles after reset deasserts; ready=1 from the following cycle.
//     reset re-asserted mid-clear restarts at index 0. wr_en and issue_en ignored in CLEAR.
//   Outputs during reset/CLEAR: ready=0, stall=1, rd_data=0, rd_busy=0.
//   RUN write: wr_en at edge -> mem[wr_addr]<=wr_data, busy[wr_addr]<=0.
//   RUN issue: issue_en at edge -> busy[issue_addr]<=1.
//   Same edge, issue_addr==wr_addr, both enabled: data written AND busy ends 1 (new producer wins).
//   ZERO_REG=1: writes/issues to addr 0 dropped; rd_data for addr 0 is 0; rd_busy for addr 0 is 0.
//   Reads combinational, zero latency. BYPASS=1 and wr_en and wr_addr==rd_addr[k] (not filtered by ZERO_REG):
//     rd_data[k]=wr_data, rd_busy[k]=0 that cycle, unless issue_en hits same addr (rd_busy[k]=1).
//   BYPASS=0: rd_data shows old value until after edge; rd_busy from stored busy bit only.
//   All NUM_RD ports independent; multiple ports same address return identical data.
//   No arithmetic; DATA_W passed unmodified; addresses full-range, no wrap beyond DEPTH-1.
// TESTING
//   reset 1 cycle, release -> ready=0 for 32 cycles, 1 on 33rd; all rd_data=0; mid-clear reset restarts count to 32.
//   RUN: write r5=0xDEADBEEF; next cycle rd_addr[0]=5 -> 0xDEADBEEF; write r0=0x1234 -> reads 0.
//   BYPASS=1: wr_en r7=0xA5A5A5A5 with rd_addr[1]=7 same cycle -> rd_data[1]=0xA5A5A5A5 combinationally; BYPASS=0 -> old value 0.
//   issue r9; rd_addr[0]=9 -> rd_busy[0]=1, stall=1; later wr r9=0x55 -> next cycle rd_busy[0]=0, stall=0, data 0x55.
//   issue r3 and write r3=0x77 same edge -> mem=0x77, rd_busy stays 1 until a second write to r3 clears it.
//   NUM_RD=4, all ports r2/r2/r31/r0 after writes -> matching values, port 3 = 0; wr_en during CLEAR -> no effect after ready.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with per-port write bypass, busy scoreboard and a one-register-per-cycle clear after reset.
// Reads are combinational (zero latency); stall is raised while clearing or when any read port hits a busy register.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    output logic                       stall,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       issue_en,
    input  logic [ADDR_W-1:0]          issue_addr,
    output logic                       ready
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    busy_q;
    logic                run_ok;
    logic                wr_ok;
    logic                iss_ok;

    always_ff @(posedge clock) begin
        state_q   <= state_d;
        clr_idx_q <= clr_idx_d;
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (reset) begin
            state_d   = CLEAR;
            clr_idx_d = '0;
        end else if (state_q == CLEAR) begin
            clr_idx_d = clr_idx_q + ADDR_W'(1);
            if (&clr_idx_q)
                state_d = RUN;
        end
    end

    // Reset is synchronous, so gate with it to keep outputs quiet in the reset cycle itself.
    assign run_ok = (state_q == RUN) && !reset;
    assign wr_ok  = run_ok && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    assign iss_ok = run_ok && issue_en && !((ZERO_REG != 0) && (issue_addr == '0));

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == CLEAR)
                mem[clr_idx_q] <= '0;
            else if (wr_ok)
                mem[wr_addr] <= wr_data;
        end
    end

    // Issue is applied after write so a new producer on the same edge keeps the register busy.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                busy_q[clr_idx_q] <= 1'b0;
            end else begin
                if (wr_ok)
                    busy_q[wr_addr] <= 1'b0;
                if (iss_ok)
                    busy_q[issue_addr] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              is_zero;
        logic              wr_hit;
        logic              iss_hit;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
        assign is_zero = (ZERO_REG != 0) && (addr == '0);
        assign wr_hit  = (BYPASS != 0) && wr_en && (wr_addr == addr);
        assign iss_hit = issue_en && (issue_addr == addr);

        always_comb begin
            data = '0;
            busy = 1'b0;
            if (run_ok && !is_zero) begin
                if (wr_hit) begin
                    data = wr_data;
                    busy = iss_hit;
                end else begin
                    data = mem[addr];
                    busy = busy_q[addr];
                end
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
        assign rd_busy[k]                  = busy;
    end

    assign ready = run_ok;
    assign stall = !run_ok || (|rd_busy);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: a 4-port bypassing file and a 2-port non-bypassing file driven by the same write/issue traffic.
module tb_regfile_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic [19:0] rd_addr_a;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_addr;

    logic [127:0] rd_data_a;
    logic [3:0]   rd_busy_a;
    logic         stall_a, ready_a;
    logic [63:0]  rd_data_b;
    logic [1:0]   rd_busy_b;
    logic         stall_b, ready_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clock(clock), .reset(reset), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .rd_busy(rd_busy_a), .stall(stall_a), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .issue_en(issue_en), .issue_addr(issue_addr), .ready(ready_a)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clock(clock), .reset(reset), .rd_addr(rd_addr_a[9:0]), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .stall(stall_b), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .issue_en(issue_en), .issue_addr(issue_addr), .ready(ready_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] p0, input logic [4:0] p1,
                          input logic [4:0] p2, input logic [4:0] p3);
        rd_addr_a = {p3, p2, p1, p0};
    endtask

    function automatic logic [31:0] rda(input int k);
        return rd_data_a[k*32 +: 32];
    endfunction

    function automatic logic [31:0] rdb(input int k);
        return rd_data_b[k*32 +: 32];
    endfunction

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0;
        set_rd(5'd5, 5'd0, 5'd0, 5'd0);
        step();
        check("rst_ready", {31'b0, ready_a}, 32'd0);
        check("rst_stall", {31'b0, stall_a}, 32'd1);

        // Partial clear, then reset again: the full count must restart.
        reset = 1'b0;
        repeat (10) step();
        check("midclr_ready", {31'b0, ready_a}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;

        for (int i = 1; i <= 32; i++) begin
            if (i == 20) begin
                wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h99;
                issue_en = 1'b1; issue_addr = 5'd6;
            end
            #1;
            if (i == 1 || i == 32) begin
                check("clr_ready", {31'b0, ready_a}, 32'd0);
                check("clr_rd_data", rda(0), 32'd0);
                check("clr_stall", {31'b0, stall_a}, 32'd1);
            end
            step();
            wr_en = 1'b0; issue_en = 1'b0;
        end
        #1;
        check("ready_a", {31'b0, ready_a}, 32'd1);
        check("ready_b", {31'b0, ready_b}, 32'd1);

        set_rd(5'd3, 5'd6, 5'd0, 5'd0);
        #1;
        check("clr_wr_ignored", rda(0), 32'd0);
        check("clr_iss_ignored", {28'b0, rd_busy_a}, 32'd0);
        check("run_stall", {31'b0, stall_a}, 32'd0);

        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        step();
        wr_en = 1'b0;
        set_rd(5'd5, 5'd0, 5'd0, 5'd0);
        #1;
        check("r5_a", rda(0), 32'hDEADBEEF);
        check("r5_b", rdb(0), 32'hDEADBEEF);

        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        step();
        wr_en = 1'b0;
        set_rd(5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        check("r0_a", rda(0), 32'd0);
        check("r0_b", rdb(0), 32'd0);

        set_rd(5'd5, 5'd7, 5'd0, 5'd0);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        #1;
        check("byp_a", rda(1), 32'hA5A5A5A5);
        check("byp_busy_a", {31'b0, rd_busy_a[1]}, 32'd0);
        check("nobyp_b", rdb(1), 32'd0);
        step();
        wr_en = 1'b0;
        #1;
        check("r7_b", rdb(1), 32'hA5A5A5A5);

        issue_en = 1'b1; issue_addr = 5'd9;
        step();
        issue_en = 1'b0;
        set_rd(5'd9, 5'd7, 5'd0, 5'd0);
        #1;
        check("r9_busy_a", {31'b0, rd_busy_a[0]}, 32'd1);
        check("r9_stall_a", {31'b0, stall_a}, 32'd1);
        check("r9_busy_b", {31'b0, rd_busy_b[0]}, 32'd1);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
        #1;
        check("r9_byp_busy_a", {31'b0, rd_busy_a[0]}, 32'd0);
        check("r9_byp_data_a", rda(0), 32'h55);
        check("r9_stored_busy_b", {31'b0, rd_busy_b[0]}, 32'd1);
        step();
        wr_en = 1'b0;
        #1;
        check("r9_free_a", {31'b0, rd_busy_a[0]}, 32'd0);
        check("r9_nostall_a", {31'b0, stall_a}, 32'd0);
        check("r9_nostall_b", {31'b0, stall_b}, 32'd0);
        check("r9_data_b", rdb(0), 32'h55);

        // Write and issue to the same register on one edge: data lands, busy stays set.
        set_rd(5'd3, 5'd7, 5'd0, 5'd0);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
        issue_en = 1'b1; issue_addr = 5'd3;
        #1;
        check("r3_byp_busy_a", {31'b0, rd_busy_a[0]}, 32'd1);
        check("r3_byp_data_a", rda(0), 32'h77);
        check("r3_old_b", rdb(0), 32'd0);
        step();
        wr_en = 1'b0; issue_en = 1'b0;
        #1;
        check("r3_busy_a", {31'b0, rd_busy_a[0]}, 32'd1);
        check("r3_busy_b", {31'b0, rd_busy_b[0]}, 32'd1);
        check("r3_data_b", rdb(0), 32'h77);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h88;
        step();
        wr_en = 1'b0;
        #1;
        check("r3_free_a", {31'b0, rd_busy_a[0]}, 32'd0);
        check("r3_data2_a", rda(0), 32'h88);

        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h22222222;
        step();
        wr_addr = 5'd31; wr_data = 32'hF0F0F0F0;
        step();
        wr_en = 1'b0;
        issue_en = 1'b1; issue_addr = 5'd0;
        step();
        issue_en = 1'b0;
        set_rd(5'd2, 5'd2, 5'd31, 5'd0);
        #1;
        check("p0_r2", rda(0), 32'h22222222);
        check("p1_r2", rda(1), 32'h22222222);
        check("p2_r31", rda(2), 32'hF0F0F0F0);
        check("p3_r0", rda(3), 32'd0);
        check("r0_busy", {28'b0, rd_busy_a}, 32'd0);

        set_rd(5'd5, 5'd0, 5'd0, 5'd0);
        reset = 1'b1;
        #1;
        check("run_rst_ready", {31'b0, ready_a}, 32'd0);
        check("run_rst_stall", {31'b0, stall_a}, 32'd1);
        check("run_rst_data", rda(0), 32'd0);
        step();
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
